// File: rtl/descrambler_pkg.sv
// Shared constants and lock-state type for the x^58+x^39+1 self-synchronizing descrambler.
package descrambler_pkg;

    localparam int DESC_W = 32;
    localparam int TAP_A  = 39;
    localparam int TAP_B  = 58;
    localparam int HIST_W = 58;
    localparam int EXT_W  = DESC_W + HIST_W;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/descrambler_32bit_if.sv
// Word-path bundle for descrambler_32bit. The optional bypass lane exists only when
// DESCRAMBLER_BYPASS_EN is defined.
//
// Handshake: a word moves on in_* when in_valid && in_ready at posedge clk, and on out_*
// when out_valid && out_ready. A source never withdraws or changes a word it is presenting
// while valid && !ready, and ready may depend combinationally on the far side's ready.
interface descrambler_32bit_if;
    import descrambler_pkg::*;

    logic              resync;
    logic [DESC_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DESC_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_locked;
    lock_state_t       state_dbg;
`ifdef DESCRAMBLER_BYPASS_EN
    logic              bypass;

    modport slave (
        input  resync, in_data, in_valid, out_ready, bypass,
        output in_ready, out_data, out_valid, out_locked, state_dbg
    );
    modport master (
        output resync, in_data, in_valid, out_ready, bypass,
        input  in_ready, out_data, out_valid, out_locked, state_dbg
    );
`else
    modport slave (
        input  resync, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_locked, state_dbg
    );
    modport master (
        output resync, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_locked, state_dbg
    );
`endif

endinterface

// File: rtl/descrambler_comb32.sv
// One 32-bit step of the descrambler: (scrambled word, history) -> (clear word, next history).
module descrambler_comb32
    import descrambler_pkg::*;
(
    input  logic [DESC_W-1:0] in_data,
    input  logic [HIST_W-1:0] hist,
    output logic [DESC_W-1:0] out_word,
    output logic [HIST_W-1:0] next_hist
);

    logic [EXT_W-1:0]  ext;
    logic [DESC_W-1:0] taps;

    // Line bit i of this word sits at ext[HIST_W+i]; its taps lie TAP_A and TAP_B bits earlier.
    assign ext       = {in_data, hist};
    assign taps      = ext[HIST_W-TAP_A +: DESC_W] ^ ext[HIST_W-TAP_B +: DESC_W];
    assign next_hist = ext[EXT_W-1 -: HIST_W];

    xor32bit u_xor (
        .a (in_data),
        .b (taps),
        .y (out_word)
    );

endmodule

// File: rtl/xor32bit.sv
// 32-bit bitwise XOR stage of the shared datapath library.
module xor32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/descrambler_32bit.sv
// Receive-side x^58+x^39+1 descrambler, 32 bits/clock, registered valid/ready output.
// Optional feature macro: DESCRAMBLER_BYPASS_EN (adds a per-word bypass lane).
module descrambler_32bit
    import descrambler_pkg::*;
#(
    parameter int LOCK_WORDS = 2
)(
    input logic          clk,
    input logic          reset,
    descrambler_32bit_if.slave bus
);

    localparam int CNT_W = $clog2(LOCK_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_WORDS);

    logic [HIST_W-1:0] hist_q;
    logic [CNT_W-1:0]  cnt_q;
    lock_state_t       state_q;
    logic [DESC_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_locked_q;

    logic              accept;
    logic              transfer;
    logic [HIST_W-1:0] hist_base;
    logic [HIST_W-1:0] hist_next;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_next;
    lock_state_t       state_base;
    lock_state_t       state_next;
    logic [DESC_W-1:0] desc_word;
    logic [DESC_W-1:0] word_sel;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign transfer     = out_valid_q && bus.out_ready;

    // resync wins over a same-cycle accept, so that word sees zeroed history and counts as word 1.
    always_comb begin
        hist_base  = bus.resync ? '0 : hist_q;
        cnt_base   = bus.resync ? '0 : cnt_q;
        state_base = bus.resync ? UNLOCKED : state_q;
        cnt_next   = cnt_base;
        state_next = state_base;
        if (state_base == UNLOCKED) begin
            cnt_next = cnt_base + CNT_W'(1);
            if (cnt_next == CNT_LOCK) begin
                state_next = LOCKED;
            end
        end
    end

    descrambler_comb32 u_comb (
        .in_data   (bus.in_data),
        .hist      (hist_base),
        .out_word  (desc_word),
        .next_hist (hist_next)
    );

`ifdef DESCRAMBLER_BYPASS_EN
    assign word_sel = bus.bypass ? bus.in_data : desc_word;
`else
    assign word_sel = desc_word;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q       <= '0;
            cnt_q        <= '0;
            state_q      <= UNLOCKED;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_locked_q <= 1'b0;
        end else begin
            hist_q  <= accept ? hist_next  : hist_base;
            cnt_q   <= accept ? cnt_next   : cnt_base;
            state_q <= accept ? state_next : state_base;
            if (accept) begin
                out_data_q   <= word_sel;
                out_valid_q  <= 1'b1;
                out_locked_q <= (state_next == LOCKED);
            end else if (transfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_locked = out_locked_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_descrambler_32bit.sv
// Self-checking bench for descrambler_32bit against a bit-serial line model.
// Build with +define+DESCRAMBLER_BYPASS_EN to also exercise the bypass lane.
module tb_descrambler_32bit;
  import descrambler_pkg::*;

  localparam int LOCK_WORDS = 2;
  localparam int N_RAND     = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  descrambler_32bit_if bus();

  descrambler_32bit #(.LOCK_WORDS(LOCK_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int errors  = 0;

  // rx_hist[k] / tx_hist[k]: line bit seen k+1 bit-times ago.
  logic rx_hist [58];
  logic tx_hist [58];
  int   rx_words;

  logic [31:0] exp_q[$];
  logic        lk_q[$];
  logic [31:0] orig_q[$];
  int          idx_q[$];

  logic [31:0] orig_w [N_RAND];
  logic [31:0] scr_w  [N_RAND];

  // ---------------- clock/reset and drivers ----------------
  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.resync    = 1'b0;
`ifdef DESCRAMBLER_BYPASS_EN
    bus.bypass    = 1'b0;
`endif
  endtask

  task automatic model_clear();
    foreach (rx_hist[k]) rx_hist[k] = 1'b0;
    rx_words = 0;
    exp_q.delete();
    lk_q.delete();
    orig_q.delete();
    idx_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic rs,
                      output logic acc, output logic xfr, output logic ov,
                      output logic [31:0] od, output logic ol);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.resync    = rs;
    #1;
    acc = iv && bus.in_ready;
    ov  = bus.out_valid;
    xfr = ov && ordy;
    od  = bus.out_data;
    ol  = bus.out_locked;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_rx(input logic [31:0] x, input logic rs, output logic [31:0] y, output logic lk);
    if (rs) begin
      foreach (rx_hist[k]) rx_hist[k] = 1'b0;
      rx_words = 0;
    end
    for (int b = 0; b < 32; b++) begin
      y[b] = x[b] ^ rx_hist[TAP_A-1] ^ rx_hist[TAP_B-1];
      for (int k = 57; k > 0; k--) rx_hist[k] = rx_hist[k-1];
      rx_hist[0] = x[b];
    end
    rx_words++;
    lk = (rx_words >= LOCK_WORDS);
  endtask

  task automatic scramble(input logic [31:0] d, output logic [31:0] s);
    for (int b = 0; b < 32; b++) begin
      s[b] = d[b] ^ tx_hist[TAP_A-1] ^ tx_hist[TAP_B-1];
      for (int k = 57; k > 0; k--) tx_hist[k] = tx_hist[k-1];
      tx_hist[0] = s[b];
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    vectors++; if (bus.out_locked !== 1'b0) begin errors++; $display("FAIL reset_out_locked: got %b want 0", bus.out_locked); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.state_dbg !== UNLOCKED) begin errors++; $display("FAIL reset_state: got %b want UNLOCKED", bus.state_dbg); end
  endtask

  task automatic test_known_vector();
    logic [31:0] kv_in  [3] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
    logic [31:0] kv_out [3] = '{32'h0000_0001, 32'h0400_0080, 32'h0000_0000};
    logic        kv_lk  [3] = '{1'b0, 1'b1, 1'b1};
    logic acc, xfr, ov, ol;
    logic [31:0] od;
    int n = 0;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      step(k < 3, (k < 3) ? kv_in[k % 3] : 32'h0, 1'b1, 1'b0, acc, xfr, ov, od, ol);
      if (xfr && n < 3) begin
        vectors++; if (od !== kv_out[n]) begin errors++; $display("FAIL known_data[%0d]: got %h want %h", n, od, kv_out[n]); end
        vectors++; if (ol !== kv_lk[n]) begin errors++; $display("FAIL known_locked[%0d]: got %b want %b", n, ol, kv_lk[n]); end
        n++;
      end
    end
    vectors++; if (n != 3) begin errors++; $display("FAIL known_count: got %0d want 3", n); end
  endtask

  task automatic test_stall();
    logic acc, xfr, ov, ol, lk;
    logic [31:0] od, a, b, c, ya, yc;
    apply_reset();
    a = $urandom(); b = $urandom(); c = $urandom();
    step(1'b1, a, 1'b1, 1'b0, acc, xfr, ov, od, ol);
    model_rx(a, 1'b0, ya, lk);
    vectors++; if (acc !== 1'b1) begin errors++; $display("FAIL stall_accept_a: got %b want 1", acc); end
    repeat (3) begin
      step(1'b1, b, 1'b0, 1'b0, acc, xfr, ov, od, ol);
      vectors++; if (acc !== 1'b0) begin errors++; $display("FAIL stall_in_ready: accepted %b want 0", acc); end
      vectors++; if (ov !== 1'b1 || od !== ya) begin errors++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", ov, od, ya); end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, acc, xfr, ov, od, ol);
    vectors++; if (xfr !== 1'b1 || od !== ya || ol !== 1'b0) begin errors++; $display("FAIL stall_release: got x=%b %h l=%b want x=1 %h l=0", xfr, od, ol, ya); end
    step(1'b1, c, 1'b1, 1'b0, acc, xfr, ov, od, ol);
    model_rx(c, 1'b0, yc, lk);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc, xfr, ov, od, ol);
    vectors++; if (xfr !== 1'b1 || od !== yc || ol !== lk) begin errors++; $display("FAIL stall_hist_kept: got x=%b %h l=%b want x=1 %h l=%b", xfr, od, ol, yc, lk); end
  endtask

  task automatic test_resync();
    logic acc, xfr, ov, ol, lk, rs, el;
    logic [31:0] od, d, y, e;
    int i, outs = 0;
    int last = 3 + LOCK_WORDS;
    apply_reset();
    for (int k = 0; k <= last; k++) begin
      rs = (k == 3);
      d  = rs ? 32'h0000_0001 : 32'($urandom());
      step(k < last, d, 1'b1, rs, acc, xfr, ov, od, ol);
      if (xfr) begin
        outs++;
        vectors++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL resync_extra: unexpected word %h", od);
        end else begin
          e = exp_q.pop_front(); el = lk_q.pop_front(); i = idx_q.pop_front();
          if (od !== e || ol !== el) begin errors++; $display("FAIL resync_word[%0d]: got %h l=%b want %h l=%b", i, od, ol, e, el); end
          if (i == 0) begin
            vectors++; if (od !== 32'h0000_0001 || ol !== 1'b0) begin errors++; $display("FAIL resync_first: got %h l=%b want 00000001 l=0", od, ol); end
          end
          if (i == LOCK_WORDS - 1) begin
            vectors++; if (ol !== 1'b1) begin errors++; $display("FAIL resync_relock: got l=%b want 1", ol); end
          end
        end
      end
      if (acc) begin
        model_rx(d, rs, y, lk);
        exp_q.push_back(y); lk_q.push_back(lk); idx_q.push_back(k >= 3 ? k - 3 : -1);
      end
    end
    vectors++; if (outs != last) begin errors++; $display("FAIL resync_count: got %0d want %0d", outs, last); end
  endtask

  task automatic test_reset_midstream();
    logic acc, xfr, ov, ol;
    logic [31:0] od;
    apply_reset();
    step(1'b1, 32'($urandom()), 1'b1, 1'b0, acc, xfr, ov, od, ol);
    step(1'b1, 32'($urandom()), 1'b0, 1'b0, acc, xfr, ov, od, ol);
    vectors++; if (ov !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", ov); end
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = $urandom();
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_locked !== 1'b0) begin errors++; $display("FAIL midrst_out_locked: got %b want 0", bus.out_locked); end
    vectors++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL midrst_out_data: got %h want 0", bus.out_data); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    model_clear();
  endtask

  task automatic test_random_stream();
    logic acc, xfr, ov, ol, lk, iv, ordy, el, stalled;
    logic [31:0] od, d, y, e, o, held;
    int i, ptr = 0, outs = 0, cyc = 0;
    apply_reset();
    foreach (tx_hist[k]) tx_hist[k] = 1'($urandom_range(0, 1));
    for (int w = 0; w < N_RAND; w++) begin
      orig_w[w] = $urandom();
      scramble(orig_w[w], scr_w[w]);
    end
    stalled = 1'b0;
    held = '0;
    while ((ptr < N_RAND || exp_q.size() > 0) && cyc < 20000) begin
      iv = (ptr < N_RAND) && ($urandom_range(0, 3) != 0);
      if (iv) d = scr_w[ptr];
      else    d = $urandom();
      ordy = ($urandom_range(0, 3) != 0);
      step(iv, d, ordy, 1'b0, acc, xfr, ov, od, ol);
      if (stalled) begin
        vectors++; if (ov !== 1'b1 || od !== held) begin errors++; $display("FAIL rand_stable: got v=%b %h want v=1 %h", ov, od, held); end
      end
      if (xfr) begin
        outs++;
        vectors++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_dup: unexpected word %h", od);
        end else begin
          e = exp_q.pop_front(); el = lk_q.pop_front(); o = orig_q.pop_front(); i = idx_q.pop_front();
          if (od !== e || ol !== el) begin errors++; $display("FAIL rand_model[%0d]: got %h l=%b want %h l=%b", i, od, ol, e, el); end
          if (i >= 2) begin
            vectors++; if (od !== o) begin errors++; $display("FAIL rand_orig[%0d]: got %h want %h", i, od, o); end
          end
        end
      end
      if (acc) begin
        model_rx(d, 1'b0, y, lk);
        exp_q.push_back(y); lk_q.push_back(lk); orig_q.push_back(orig_w[ptr]); idx_q.push_back(ptr);
        ptr++;
      end
      stalled = ov && !ordy;
      held = od;
      cyc++;
    end
    vectors++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout: sent %0d of %0d", ptr, N_RAND); end
    vectors++; if (outs != N_RAND) begin errors++; $display("FAIL rand_count: got %0d want %0d", outs, N_RAND); end
  endtask

`ifdef DESCRAMBLER_BYPASS_EN
  task automatic test_bypass();
    logic acc, xfr, ov, ol, lk, byp, el;
    logic [31:0] od, d, y, e;
    int i, outs = 0;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      byp = (k == 2);
      d = byp ? 32'hDEAD_BEEF : 32'($urandom());
      bus.bypass = byp;
      step(k < 5, d, 1'b1, 1'b0, acc, xfr, ov, od, ol);
      if (xfr) begin
        outs++;
        vectors++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL byp_extra: unexpected word %h", od);
        end else begin
          e = exp_q.pop_front(); el = lk_q.pop_front(); i = idx_q.pop_front();
          if (od !== e || ol !== el) begin errors++; $display("FAIL byp_word[%0d]: got %h l=%b want %h l=%b", i, od, ol, e, el); end
        end
      end
      if (acc) begin
        model_rx(d, 1'b0, y, lk);
        exp_q.push_back(byp ? 32'hDEAD_BEEF : y); lk_q.push_back(lk); idx_q.push_back(k);
      end
    end
    bus.bypass = 1'b0;
    vectors++; if (outs != 5) begin errors++; $display("FAIL byp_count: got %0d want 5", outs); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    test_reset();
    test_known_vector();
    test_stall();
    test_resync();
    test_reset_midstream();
    test_random_stream();
`ifdef DESCRAMBLER_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
